bin_to_bcd_seq: RTL

//  Multi-cycle, parametrised double-dabble converter: binary word in, packed BCD digits out.

---
 rtl/bcd_pkg.sv | 14 +
 rtl/bcd_digit_adjust.sv | 16 +
 rtl/bin_to_bcd_seq.sv | 127 ++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
// Holds the FSM state encoding and the per-digit double-dabble correction.
package bcd_pkg;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcd_state_t;

   localparam logic [3:0] BCD_NINE = 4'h9;

   // A digit of 5 or more would exceed 9 after the next doubling, so pre-bias it by 3.
   function automatic logic [3:0] dabble(input logic [3:0] d);
      return (d >= 4'd5) ? d + 4'd3 : d;
   endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Applies the double-dabble correction to every digit of a packed BCD word.
// Purely combinational; the top shifts the corrected word on each clock.
module bcd_digit_adjust
   import bcd_pkg::*;
#(
   parameter int DIGITS = 10
) (
   input  logic [4*DIGITS-1:0] bcd_in,
   output logic [4*DIGITS-1:0] bcd_adj
);

   for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      assign bcd_adj[4*i +: 4] = dabble(bcd_in[4*i +: 4]);
   end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Multi-cycle double-dabble converter with valid/ready handshakes, one input bit per clock.
// Saturates to all nines on overflow and reports which digits are significant for blanking.
module bin_to_bcd_seq
   import bcd_pkg::*;
#(
   parameter int BIN_W  = 32,
   parameter int DIGITS = 10
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [BIN_W-1:0]    bin,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [4*DIGITS-1:0] bcd,
   output logic [DIGITS-1:0]   digit_en,
   output logic                ovf
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(BIN_W + 1);

   bcd_state_t         state;
   bcd_state_t         state_next;
   logic [BIN_W-1:0]   bin_sr;
   logic [BIN_W-1:0]   bin_shift;
   logic [BCD_W-1:0]   bcd_sr;
   logic [BCD_W-1:0]   bcd_adj;
   logic [BCD_W-1:0]   bcd_shift;
   logic [BCD_W-1:0]   bcd_result;
   logic [DIGITS-1:0]  digit_en_next;
   logic [CNT_W-1:0]   cnt;
   logic               carry_out;
   logic               ovf_acc;
   logic               ovf_next;
   logic               any_nz;
   logic               accept;
   logic               shifting;
   logic               last_shift;
   logic               release_out;

   bcd_digit_adjust #(.DIGITS(DIGITS)) u_adjust (
      .bcd_in  (bcd_sr),
      .bcd_adj (bcd_adj)
   );

   // The bit pushed out of the top digit means the value no longer fits in DIGITS digits.
   assign {carry_out, bcd_shift, bin_shift} = {bcd_adj, bin_sr, 1'b0};
   assign ovf_next   = ovf_acc | carry_out;
   assign bcd_result = ovf_next ? {DIGITS{BCD_NINE}} : bcd_shift;

   assign in_ready    = (state == IDLE);
   assign accept      = (state == IDLE) && in_valid;
   assign shifting    = (state == SHIFT);
   assign last_shift  = shifting && (cnt == CNT_W'(1));
   assign release_out = (state == DONE) && out_ready;

   // A digit is significant when it or any more significant digit is nonzero.
   always_comb begin
      digit_en_next = '0;
      any_nz        = 1'b0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         any_nz           = any_nz | (bcd_shift[4*i +: 4] != 4'd0);
         digit_en_next[i] = any_nz;
      end
      digit_en_next[0] = 1'b1;
      if (ovf_next) begin
         digit_en_next = '1;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (in_valid)   state_next = SHIFT;
         SHIFT:   if (last_shift) state_next = DONE;
         DONE:    if (out_ready)  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bin_sr  <= '0;
         bcd_sr  <= '0;
         ovf_acc <= 1'b0;
         cnt     <= '0;
      end else if (accept) begin
         bin_sr  <= bin;
         bcd_sr  <= '0;
         ovf_acc <= 1'b0;
         cnt     <= CNT_W'(BIN_W);
      end else if (shifting) begin
         bin_sr  <= bin_shift;
         bcd_sr  <= bcd_shift;
         ovf_acc <= ovf_next;
         cnt     <= cnt - CNT_W'(1);
      end
   end

   // Result registers only move on the final shift, so they hold steady through IDLE and SHIFT.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         bcd       <= '0;
         digit_en  <= '0;
         ovf       <= 1'b0;
      end else if (last_shift) begin
         out_valid <= 1'b1;
         bcd       <= bcd_result;
         digit_en  <= digit_en_next;
         ovf       <= ovf_next;
      end else if (release_out) begin
         out_valid <= 1'b0;
      end
   end

endmodule
